// File: rtl/aes_pkg.sv
// Shared definitions for the aes_128 host-side stream controller: block width,
// mode encoding and controller state encoding.
package aes_pkg;

  localparam int BLK_W = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_WAIT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/aes_128_stream_ctrl.sv
// Stream initiator for one aes_128 core: accepts a block, clears/enables the core,
// collects the result and returns it on a valid/ready stream. CBC chaining is built
// in when AES_STREAM_CBC_EN is defined; otherwise the block runs plain ECB.
module aes_128_stream_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BLK_W-1:0] key_in,
  input  logic             key_load,
  input  logic [BLK_W-1:0] iv_in,
  input  logic             iv_load,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [BLK_W-1:0] s_data,
  input  logic             s_mode,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_W-1:0] m_data,
  output logic             busy,
  output logic             err,
  output logic             aes_reset,
  output logic             aes_enable,
  output logic             aes_mode,
  output logic [BLK_W-1:0] aes_key,
  output logic [BLK_W-1:0] aes_data_in,
  input  logic [BLK_W-1:0] aes_data_out,
  input  logic             aes_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_req;
  logic [BLK_W-1:0] core_in;
  logic [BLK_W-1:0] result;

`ifdef AES_STREAM_CBC_EN
  logic [BLK_W-1:0] chain;
  logic [BLK_W-1:0] blk_raw;

  assign load_req = key_load | iv_load;
  assign core_in  = (s_mode == MODE_DEC) ? s_data : (s_data ^ chain);
  assign result   = (aes_mode == MODE_DEC) ? (aes_data_out ^ chain) : aes_data_out;
`else
  logic unused_iv;

  assign unused_iv = ^{iv_in, iv_load};
  assign load_req  = key_load;
  assign core_in   = s_data;
  assign result    = aes_data_out;
`endif

  // Register loads win over a block offered in the same IDLE cycle.
  assign s_ready    = reset && (state == ST_IDLE) && !load_req;
  assign aes_reset  = !reset || (state == ST_CLR);
  assign aes_enable = (state == ST_RUN);
  assign m_valid    = (state == ST_OUT);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so a reset mid-block leaves no stale key,
    // chain or result visible on the core or output ports.
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      aes_mode    <= MODE_ENC;
      err         <= 1'b0;
      aes_key     <= '0;
      aes_data_in <= '0;
      m_data      <= '0;
`ifdef AES_STREAM_CBC_EN
      chain       <= '0;
      blk_raw     <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (key_load) aes_key <= key_in;
`ifdef AES_STREAM_CBC_EN
          if (iv_load) chain <= iv_in;
          if (s_valid && s_ready) blk_raw <= s_data;
`endif
          if (s_valid && s_ready) begin
            aes_data_in <= core_in;
            aes_mode    <= s_mode;
            state       <= ST_CLR;
          end
        end
        ST_CLR: begin
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (aes_done) begin
            state <= ST_WAIT;
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          m_data <= result;
`ifdef AES_STREAM_CBC_EN
          chain  <= (aes_mode == MODE_DEC) ? blk_raw : result;
`endif
          state  <= ST_OUT;
        end
        ST_OUT: begin
          if (m_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_stream_ctrl.sv
// Self-checking bench for aes_128_stream_ctrl with a behavioural core model
// (result = data_in ^ key, done 11 cycles after first enable).
module tb_aes_128_stream_ctrl;
  import aes_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [BLK_W-1:0] key_in, iv_in, s_data, m_data, aes_key, aes_data_in, aes_data_out;
  logic             key_load, iv_load, s_valid, s_ready, s_mode, m_valid, m_ready;
  logic             busy, err, aes_reset, aes_enable, aes_mode, aes_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic hang  = 1'b0;
  int core_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_128_stream_ctrl #(.TIMEOUT(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load), .iv_in(iv_in),
    .iv_load(iv_load), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_mode(s_mode), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .err(err), .aes_reset(aes_reset), .aes_enable(aes_enable), .aes_mode(aes_mode),
    .aes_key(aes_key), .aes_data_in(aes_data_in), .aes_data_out(aes_data_out),
    .aes_done(aes_done)
  );

  // Core model: done rises 11 enabled cycles after clear and stays up until the next clear.
  initial begin
    aes_done     = 1'b0;
    aes_data_out = '0;
  end
  always @(posedge clk) begin
    if (aes_reset) begin
      core_cnt <= 0;
      aes_done <= 1'b0;
    end else if (aes_enable && !aes_done && !hang) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 == 11) begin
        aes_done     <= 1'b1;
        aes_data_out <= aes_data_in ^ aes_key;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s_ready"},    128'(s_ready),    128'(0));
    check({tag, "_m_valid"},    128'(m_valid),    128'(0));
    check({tag, "_busy"},       128'(busy),       128'(0));
    check({tag, "_err"},        128'(err),        128'(0));
    check({tag, "_aes_enable"}, 128'(aes_enable), 128'(0));
    check({tag, "_aes_mode"},   128'(aes_mode),   128'(0));
    check({tag, "_aes_reset"},  128'(aes_reset),  128'(1));
    check({tag, "_aes_key"},    aes_key,          128'(0));
    check({tag, "_aes_din"},    aes_data_in,      128'(0));
    check({tag, "_m_data"},     m_data,           128'(0));
  endtask

  // Loads the key and, in CBC builds, zeroes the chain so each case starts clean.
  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key_in = k; key_load = 1'b1; iv_in = '0; iv_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0; iv_load = 1'b0;
  endtask

  // Returns at the negedge of the CLR cycle; t_acc = -1 if never accepted.
  task automatic send(input logic [127:0] d, input logic m, output int t_acc);
    t_acc = -1;
    @(negedge clk);
    s_data = d; s_mode = m; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (s_ready) begin
        t_acc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Called at the CLR negedge; returns 1 unit after the first negedge with m_valid high.
  task automatic wait_out(input int t_acc, input logic m, output int lat, output int pulses,
                          output bit busy_ok, output bit mode_ok, output logic [127:0] din);
    lat = -1; pulses = 0; busy_ok = 1'b1; mode_ok = 1'b1; din = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (aes_reset) pulses++;
      if (!busy) busy_ok = 1'b0;
      if (aes_enable) begin
        din = aes_data_in;
        if (aes_mode !== m) mode_ok = 1'b0;
      end
      if (m_valid) begin
        lat = cyc - t_acc;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic         mode;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t, lat, pulses, en_cnt;
    bit busy_ok, mode_ok, stable, sr_low, mv, dropped;
    logic [127:0] din, d0, exp2;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                MODE_ENC, 128'h00102030405060708090a0b0c0d0e0f0};
    vecs[1] = '{{16{8'hff}}, 128'h0, MODE_DEC, {16{8'hff}}};
    vecs[2] = '{128'h0, 128'h0123456789abcdeffedcba9876543210, MODE_ENC,
                128'h0123456789abcdeffedcba9876543210};
    vecs[3] = '{{16{8'ha5}}, {16{8'h5a}}, MODE_DEC, {16{8'hff}}};
    vecs[4] = '{128'h80000000000000000000000000000001, 128'h0, MODE_ENC,
                128'h80000000000000000000000000000001};

    reset = 1'b0; key_in = '0; key_load = 1'b0; iv_in = '0; iv_load = 1'b0;
    s_valid = 1'b0; s_data = '0; s_mode = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b1;

    // Table-driven single blocks with m_ready held high.
    m_ready = 1'b1;
    foreach (vecs[i]) begin
      load_key(vecs[i].key);
      send(vecs[i].data, vecs[i].mode, t);
      wait_out(t, vecs[i].mode, lat, pulses, busy_ok, mode_ok, din);
      check($sformatf("v%0d_latency", i), 128'(lat), 128'(15));
      check($sformatf("v%0d_data", i), m_data, vecs[i].exp);
      check($sformatf("v%0d_clr_pulses", i), 128'(pulses), 128'(1));
      check($sformatf("v%0d_busy", i), 128'(busy_ok), 128'(1));
      check($sformatf("v%0d_mode", i), 128'(mode_ok), 128'(1));
      @(negedge clk); #1;
      check($sformatf("v%0d_mvalid_drop", i), 128'(m_valid), 128'(0));
      check($sformatf("v%0d_idle", i), 128'(busy), 128'(0));
    end
    check("err_clean", 128'(err), 128'(0));

    // Backpressure: result held 20 cycles, input refused, next block right after handshake.
    load_key({16{8'h11}});
    m_ready = 1'b0;
    send({16{8'h22}}, MODE_ENC, t);
    wait_out(t, MODE_ENC, lat, pulses, busy_ok, mode_ok, din);
    check("bp_latency", 128'(lat), 128'(15));
    check("bp_data", m_data, {16{8'h33}});
    d0 = m_data;
    @(negedge clk);
    s_data = {16{8'h44}}; s_mode = MODE_ENC; s_valid = 1'b1;
    stable = 1'b1; sr_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m_valid !== 1'b1 || m_data !== d0) stable = 1'b0;
      if (s_ready !== 1'b0) sr_low = 1'b0;
      @(negedge clk);
    end
    check("bp_stable", 128'(stable), 128'(1));
    check("bp_s_ready_low", 128'(sr_low), 128'(1));
    m_ready = 1'b1;
    #1;
    check("bp_still_valid", 128'(m_valid), 128'(1));
    @(negedge clk); #1;
    check("bp_released", 128'(m_valid), 128'(0));
    check("bp_next_ready", 128'(s_ready), 128'(1));
    t = cyc;
    @(negedge clk);
    s_valid = 1'b0;
`ifdef AES_STREAM_CBC_EN
    exp2 = {16{8'h66}};
`else
    exp2 = {16{8'h55}};
`endif
    wait_out(t, MODE_ENC, lat, pulses, busy_ok, mode_ok, din);
    check("b2b_latency", 128'(lat), 128'(15));
    check("b2b_data", m_data, exp2);

    // Timeout: core never completes.
    hang = 1'b1;
    load_key({16{8'h12}});
    send({16{8'h99}}, MODE_ENC, t);
    en_cnt = 0; mv = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (aes_enable) en_cnt++;
      if (m_valid) mv = 1'b1;
      if (!busy) begin
        dropped = 1'b1;
        break;
      end
      @(negedge clk);
    end
    hang = 1'b0;
    check("to_run_cycles", 128'(en_cnt), 128'(32));
    check("to_err", 128'(err), 128'(1));
    check("to_idle", 128'(dropped), 128'(1));
    check("to_no_beat", 128'(mv), 128'(0));
    load_key({16{8'h0c}});
    send({16{8'hc0}}, MODE_ENC, t);
    wait_out(t, MODE_ENC, lat, pulses, busy_ok, mode_ok, din);
    check("to_recover_data", m_data, {16{8'hcc}});
    check("to_err_sticky", 128'(err), 128'(1));

    // Priority: key_load beats s_valid; later key_load while busy is ignored.
    load_key('0);
    @(negedge clk);
    key_in = {16{8'h01}}; key_load = 1'b1;
    s_data = {8{16'h1234}}; s_mode = MODE_ENC; s_valid = 1'b1;
    #1;
    check("prio_refused", 128'(s_ready), 128'(0));
    @(negedge clk);
    key_load = 1'b0; key_in = {16{8'hee}};
    #1;
    check("prio_taken_next", 128'(s_ready), 128'(1));
    t = cyc;
    @(negedge clk);
    s_valid = 1'b0;
    check("prio_key", aes_key, {16{8'h01}});
    key_load = 1'b1;
    wait_out(t, MODE_ENC, lat, pulses, busy_ok, mode_ok, din);
    key_load = 1'b0;
    check("busy_key_ignored", aes_key, {16{8'h01}});
    check("prio_latency", 128'(lat), 128'(15));
    check("prio_data", m_data, {8{16'h1335}});

`ifdef AES_STREAM_CBC_EN
    // CBC round trip with iv = all ones and key = 0f..0f.
    load_key({16{8'h0f}});
    @(negedge clk); iv_in = {16{8'hff}}; iv_load = 1'b1;
    @(negedge clk); iv_load = 1'b0;
    send('0, MODE_ENC, t);
    wait_out(t, MODE_ENC, lat, pulses, busy_ok, mode_ok, din);
    check("cbc_enc1", m_data, {16{8'hf0}});
    send('0, MODE_ENC, t);
    wait_out(t, MODE_ENC, lat, pulses, busy_ok, mode_ok, din);
    check("cbc_enc2_core_in", din, {16{8'hf0}});
    check("cbc_enc2", m_data, {16{8'hff}});
    @(negedge clk); iv_in = {16{8'hff}}; iv_load = 1'b1;
    @(negedge clk); iv_load = 1'b0;
    send({16{8'hf0}}, MODE_DEC, t);
    wait_out(t, MODE_DEC, lat, pulses, busy_ok, mode_ok, din);
    check("cbc_dec1", m_data, 128'(0));
    send({16{8'hff}}, MODE_DEC, t);
    wait_out(t, MODE_DEC, lat, pulses, busy_ok, mode_ok, din);
    check("cbc_dec2_core_in", din, {16{8'hff}});
    check("cbc_dec2", m_data, 128'(0));
`endif

    // Reset in the middle of RUN abandons the block.
    load_key({16{8'h33}});
    send({16{8'h77}}, MODE_ENC, t);
    repeat (4) @(negedge clk);
    #1;
    check("mid_in_run", 128'(aes_enable), 128'(1));
    reset = 1'b0;
    @(negedge clk); #1;
    check_reset_state("mid");
    reset = 1'b1;
    mv = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (m_valid) mv = 1'b1;
    end
    check("mid_no_beat", 128'(mv), 128'(0));
    check("mid_idle", 128'(busy), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
